// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  localparam int unsigned FrameBits    = 10;
  localparam int unsigned DataBits     = FrameBits - 2;
  localparam int unsigned ClksWDefault = 15;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with head read-out; pointers wrap modulo Depth.
module uart_tx_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] rdata_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = AddrW + 1;

  logic [Width-1:0] r_mem [Depth];
  logic [AddrW-1:0] r_wr_ptr;
  logic [AddrW-1:0] r_rd_ptr;
  logic [CntW-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_count == CntW'(Depth));
  assign empty_o = (r_count == '0);
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign rdata_o = r_mem[r_rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AddrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AddrW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_push && !reset) r_mem[r_wr_ptr] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: FIFO-buffered bytes serialized LSB-first on an idle-high line.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned ClksW = ClksWDefault
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [ClksW-1:0] clks_per_bit_i,
  input  logic             tx_valid_i,
  input  logic [7:0]       tx_byte_i,
  output logic             tx_ready_o,
  output logic             tx_o,
  output logic             tx_busy_o,
  output logic             tx_done_o,
  output logic             fifo_empty_o
);

  localparam int unsigned IdxW = $clog2(DataBits);

  tx_state_e        r_state;
  tx_state_e        w_state_nxt;
  logic [ClksW-1:0] r_clk_cnt;
  logic [ClksW-1:0] w_clk_cnt_nxt;
  logic [ClksW-1:0] r_period;
  logic [ClksW-1:0] w_period_nxt;
  logic [ClksW-1:0] w_period_in;
  logic [IdxW-1:0]  r_bit_idx;
  logic [IdxW-1:0]  w_bit_idx_nxt;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_nxt;
  logic             r_tx;
  logic             r_busy;
  logic             r_done;
  logic             w_tx_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_last;
  logic             w_ready;
  logic             w_push;
  logic             w_pop;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [7:0]       w_rdata;

  assign w_ready      = !w_fifo_full && !reset;
  assign w_push       = tx_valid_i && w_ready;
  assign w_period_in  = (clks_per_bit_i == '0) ? ClksW'(1) : clks_per_bit_i;
  assign w_last       = (r_clk_cnt == r_period - ClksW'(1));

  assign tx_ready_o   = w_ready;
  assign tx_o         = r_tx;
  assign tx_busy_o    = r_busy;
  assign tx_done_o    = r_done;
  assign fifo_empty_o = w_fifo_empty;

  uart_tx_fifo #(
    .Depth (Depth),
    .Width (8)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (w_push),
    .wdata_i (tx_byte_i),
    .pop_i   (w_pop),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty),
    .rdata_o (w_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_clk_cnt <= '0;
      r_period  <= ClksW'(1);
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_clk_cnt <= w_clk_cnt_nxt;
      r_period  <= w_period_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_tx      <= w_tx_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Next-state logic; the frame's bit period is captured whenever a byte is popped.
  always_comb begin
    w_state_nxt   = r_state;
    w_clk_cnt_nxt = r_clk_cnt + ClksW'(1);
    w_period_nxt  = r_period;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_pop         = 1'b0;

    case (r_state)
      IDLE: begin
        w_clk_cnt_nxt = '0;
        if (!w_fifo_empty) begin
          w_pop        = 1'b1;
          w_shift_nxt  = w_rdata;
          w_period_nxt = w_period_in;
          w_state_nxt  = START;
        end
      end
      START: begin
        if (w_last) begin
          w_clk_cnt_nxt = '0;
          w_bit_idx_nxt = '0;
          w_state_nxt   = DATA;
        end
      end
      DATA: begin
        if (w_last) begin
          w_clk_cnt_nxt = '0;
          w_shift_nxt   = {1'b0, r_shift[7:1]};
          if (r_bit_idx == IdxW'(DataBits - 1)) begin
            w_bit_idx_nxt = '0;
            w_state_nxt   = STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + IdxW'(1);
          end
        end
      end
      STOP: begin
        if (w_last) begin
          w_clk_cnt_nxt = '0;
          if (!w_fifo_empty) begin
            w_pop        = 1'b1;
            w_shift_nxt  = w_rdata;
            w_period_nxt = w_period_in;
            w_state_nxt  = START;
          end else begin
            w_state_nxt  = IDLE;
          end
        end
      end
      default: begin
        w_clk_cnt_nxt = '0;
        w_state_nxt   = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they align with the state they describe.
  always_comb begin
    w_tx_nxt   = 1'b1;
    w_busy_nxt = (w_state_nxt != IDLE);
    w_done_nxt = (w_state_nxt == STOP) && (w_clk_cnt_nxt == w_period_nxt - ClksW'(1));
    case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_shift_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame shape, latency, back-to-back, backpressure, reset and period latching.
module tb_uart_tx;
  import uart_pkg::*;

  logic        clock;
  logic        reset;
  logic [14:0] clks_per_bit_i;
  logic        tx_valid_i;
  logic [7:0]  tx_byte_i;
  logic        tx_ready_o;
  logic        tx_o;
  logic        tx_busy_o;
  logic        tx_done_o;
  logic        fifo_empty_o;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  tx_q [8];
  int          n_q;
  logic        saw_stall;
  int          lat;
  int          bad;

  uart_tx #(
    .Depth (4),
    .ClksW (15)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .clks_per_bit_i (clks_per_bit_i),
    .tx_valid_i     (tx_valid_i),
    .tx_byte_i      (tx_byte_i),
    .tx_ready_o     (tx_ready_o),
    .tx_o           (tx_o),
    .tx_busy_o      (tx_busy_o),
    .tx_done_o      (tx_done_o),
    .fifo_empty_o   (fifo_empty_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Push tx_q[0..n_q-1] in order, holding each byte until accepted.
  task automatic push_all();
    logic acc;
    int   guard;
    for (int i = 0; i < n_q; i++) begin
      tx_valid_i = 1'b1;
      tx_byte_i  = tx_q[i];
      guard      = 0;
      do begin
        acc = tx_ready_o;
        if (!acc) saw_stall = 1'b1;
        @(posedge clock); #1;
        guard++;
      end while (!acc && guard < 200);
      if (!acc) check("push_timeout", 32'(acc), 32'(1));
    end
    tx_valid_i = 1'b0;
  endtask

  task automatic wait_start(input int limit, output int l);
    l = 0;
    while (tx_o !== 1'b0 && l < limit) begin
      @(posedge clock); #1;
      l++;
    end
    if (tx_o !== 1'b0) check("start_timeout", 32'(tx_o), 32'(0));
  endtask

  // Called at the first cycle of a frame; returns at the first cycle after it.
  task automatic expect_frame(input logic [7:0] b, input int p, input string tag);
    logic [FrameBits-1:0] fr;
    logic first;
    int   diff;
    int   busy_low;
    int   done_cnt;
    int   done_pos;
    fr       = {1'b1, b, 1'b0};
    busy_low = 0;
    done_cnt = 0;
    done_pos = -1;
    for (int k = 0; k < int'(FrameBits); k++) begin
      diff  = 0;
      first = tx_o;
      for (int c = 0; c < p; c++) begin
        if (tx_o !== first) diff++;
        if (tx_busy_o !== 1'b1) busy_low++;
        if (tx_done_o === 1'b1) begin
          done_cnt++;
          done_pos = k * p + c;
        end
        @(posedge clock); #1;
      end
      check($sformatf("%s.bit%0d", tag, k), 32'(first), 32'(fr[k]));
      check($sformatf("%s.hold%0d", tag, k), 32'(diff), 32'(0));
    end
    check($sformatf("%s.done_cnt", tag), 32'(done_cnt), 32'(1));
    check($sformatf("%s.done_pos", tag), 32'(done_pos), 32'(int'(FrameBits) * p - 1));
    check($sformatf("%s.busy", tag), 32'(busy_low), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    tx_valid_i     = 1'b0;
    tx_byte_i      = 8'h00;
    clks_per_bit_i = 15'd87;
    saw_stall      = 1'b0;
    n_q            = 0;
    repeat (3) @(posedge clock);
    #1;
    check("rst.tx", 32'(tx_o), 32'(1));
    check("rst.busy", 32'(tx_busy_o), 32'(0));
    check("rst.done", 32'(tx_done_o), 32'(0));
    check("rst.empty", 32'(fifo_empty_o), 32'(1));
    check("rst.ready", 32'(tx_ready_o), 32'(0));
    reset = 1'b0;
    #1;
    check("rst.ready_rel", 32'(tx_ready_o), 32'(1));

    // P=87, single 0xA5
    tx_q[0] = 8'hA5; n_q = 1;
    push_all();
    wait_start(50, lat);
    check("t1.lat", 32'(lat), 32'(1));
    expect_frame(8'hA5, 87, "t1");
    check("t1.idle_tx", 32'(tx_o), 32'(1));
    check("t1.idle_busy", 32'(tx_busy_o), 32'(0));
    check("t1.idle_empty", 32'(fifo_empty_o), 32'(1));

    // P=4, three back-to-back frames
    clks_per_bit_i = 15'd4;
    tx_q[0] = 8'h00; tx_q[1] = 8'hFF; tx_q[2] = 8'h3C; n_q = 3;
    fork
      push_all();
      begin
        wait_start(50, lat);
        for (int i = 0; i < 3; i++) expect_frame(tx_q[i], 4, $sformatf("t2.f%0d", i));
      end
    join
    check("t2.end_busy", 32'(tx_busy_o), 32'(0));

    // P=2, six bytes against a 4-deep FIFO
    clks_per_bit_i = 15'd2;
    tx_q[0] = 8'h01; tx_q[1] = 8'h80; tx_q[2] = 8'hC3;
    tx_q[3] = 8'h7E; tx_q[4] = 8'h96; tx_q[5] = 8'h5A; n_q = 6;
    saw_stall = 1'b0;
    fork
      push_all();
      begin
        wait_start(50, lat);
        for (int i = 0; i < 6; i++) expect_frame(tx_q[i], 2, $sformatf("t3.f%0d", i));
      end
    join
    check("t3.stall", 32'(saw_stall), 32'(1));
    check("t3.ready", 32'(tx_ready_o), 32'(1));
    check("t3.empty", 32'(fifo_empty_o), 32'(1));

    // P=0 behaves as P=1
    clks_per_bit_i = 15'd0;
    tx_q[0] = 8'h96; n_q = 1;
    push_all();
    wait_start(50, lat);
    check("t4a.lat", 32'(lat), 32'(1));
    expect_frame(8'h96, 1, "t4a");

    // Period change mid-frame applies only to the next frame
    clks_per_bit_i = 15'd8;
    tx_q[0] = 8'hC5; tx_q[1] = 8'h3A; n_q = 2;
    fork
      begin
        push_all();
        repeat (10) @(posedge clock);
        #1;
        clks_per_bit_i = 15'd3;
      end
      begin
        wait_start(50, lat);
        expect_frame(8'hC5, 8, "t4b.f0");
        expect_frame(8'h3A, 3, "t4b.f1");
      end
    join

    // Reset during DATA with two bytes queued
    clks_per_bit_i = 15'd4;
    tx_q[0] = 8'h11; tx_q[1] = 8'h22; tx_q[2] = 8'h33; n_q = 3;
    push_all();
    repeat (8) @(posedge clock);
    #1;
    check("t5.pre_empty", 32'(fifo_empty_o), 32'(0));
    check("t5.pre_busy", 32'(tx_busy_o), 32'(1));
    reset = 1'b1;
    @(posedge clock); #1;
    check("t5.rst_tx", 32'(tx_o), 32'(1));
    check("t5.rst_busy", 32'(tx_busy_o), 32'(0));
    check("t5.rst_empty", 32'(fifo_empty_o), 32'(1));
    check("t5.rst_ready", 32'(tx_ready_o), 32'(0));
    reset = 1'b0;
    bad = 0;
    repeat (30) begin
      @(posedge clock); #1;
      if (tx_o !== 1'b1 || tx_busy_o !== 1'b0) bad++;
    end
    check("t5.quiet", 32'(bad), 32'(0));
    tx_q[0] = 8'hE1; n_q = 1;
    push_all();
    wait_start(50, lat);
    check("t5.lat", 32'(lat), 32'(1));
    expect_frame(8'hE1, 4, "t5");

    // Push on empty FIFO during the last STOP cycle: one idle cycle, no bypass
    clks_per_bit_i = 15'd2;
    tx_q[0] = 8'h5A; n_q = 1;
    push_all();
    wait_start(50, lat);
    repeat (19) begin
      @(posedge clock); #1;
    end
    check("t6.done", 32'(tx_done_o), 32'(1));
    tx_valid_i = 1'b1;
    tx_byte_i  = 8'hA3;
    @(posedge clock); #1;
    tx_valid_i = 1'b0;
    check("t6.gap_tx", 32'(tx_o), 32'(1));
    check("t6.gap_busy", 32'(tx_busy_o), 32'(0));
    check("t6.gap_empty", 32'(fifo_empty_o), 32'(0));
    wait_start(50, lat);
    check("t6.lat", 32'(lat), 32'(1));
    expect_frame(8'hA3, 2, "t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
